// File: rtl/mem_access_stage.sv
// Memory access stage: sits after EX/MEM, drives a req/ack data-memory port,
// stalls upstream while an access is outstanding and produces the MEM/WB
// pipeline register. Misaligned word accesses retire without a request and
// memory timeouts abort the access and raise a sticky flag.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ALU_Res_i,
  input  logic [31:0] Write_Data_i,
  input  logic [4:0]  RdAddr_i,
  input  logic        MemToReg_i,
  input  logic        RegWrite_i,
  input  logic        MemWrite_i,
  input  logic        MemRead_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] ALU_Res_o,
  output logic [31:0] Mem_Data_o,
  output logic [4:0]  RdAddr_o,
  output logic        MemToReg_o,
  output logic        RegWrite_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              w_memop;
  logic              w_aligned;
  logic              w_tmo_hit;

  logic              w_req_nxt;
  logic              w_we_nxt;
  logic [31:0]       w_addr_nxt;
  logic [31:0]       w_wdata_nxt;
  logic [31:0]       w_alu_nxt;
  logic [31:0]       w_mdata_nxt;
  logic [4:0]        w_rd_nxt;
  logic              w_m2r_nxt;
  logic              w_rw_nxt;
  logic              w_mis_nxt;
  logic              w_tmo_nxt;

  assign w_memop   = MemRead_i | MemWrite_i;
  assign w_aligned = (ALU_Res_i[1:0] == 2'b00);
  assign w_tmo_hit = (r_state == BUSY) && !dmem_ack_i &&
                     (r_cnt == CNT_W'(TIMEOUT - 1));

  // FSM state and timeout counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, stall and next values of all registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = dmem_req_o;
    w_we_nxt    = dmem_we_o;
    w_addr_nxt  = dmem_addr_o;
    w_wdata_nxt = dmem_wdata_o;
    w_alu_nxt   = ALU_Res_o;
    w_mdata_nxt = Mem_Data_o;
    w_rd_nxt    = RdAddr_o;
    w_m2r_nxt   = MemToReg_o;
    w_rw_nxt    = RegWrite_o;
    w_mis_nxt   = 1'b0;
    w_tmo_nxt   = timeout_o;
    stall_o     = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_memop) begin
          w_alu_nxt = ALU_Res_i;
          w_rd_nxt  = RdAddr_i;
          w_m2r_nxt = MemToReg_i;
          w_rw_nxt  = RegWrite_i;
        end else if (!w_aligned) begin
          w_alu_nxt = ALU_Res_i;
          w_rd_nxt  = RdAddr_i;
          w_m2r_nxt = 1'b0;
          w_rw_nxt  = 1'b0;
          w_mis_nxt = 1'b1;
        end else begin
          stall_o     = 1'b1;
          w_state_nxt = BUSY;
          w_cnt_nxt   = '0;
          w_req_nxt   = 1'b1;
          w_we_nxt    = MemWrite_i;
          w_addr_nxt  = ALU_Res_i;
          w_wdata_nxt = Write_Data_i;
          w_m2r_nxt   = 1'b0;
          w_rw_nxt    = 1'b0;
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (dmem_ack_i) begin
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
          w_alu_nxt   = ALU_Res_i;
          w_rd_nxt    = RdAddr_i;
          w_m2r_nxt   = MemToReg_i;
          w_rw_nxt    = RegWrite_i;
          if (!dmem_we_o) w_mdata_nxt = dmem_rdata_i;
        end else if (w_tmo_hit) begin
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
          w_alu_nxt   = ALU_Res_i;
          w_rd_nxt    = RdAddr_i;
          w_m2r_nxt   = 1'b0;
          w_rw_nxt    = 1'b0;
          w_tmo_nxt   = 1'b1;
        end else begin
          stall_o   = 1'b1;
          w_m2r_nxt = 1'b0;
          w_rw_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory port and MEM/WB output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      ALU_Res_o    <= '0;
      Mem_Data_o   <= '0;
      RdAddr_o     <= '0;
      MemToReg_o   <= 1'b0;
      RegWrite_o   <= 1'b0;
      misalign_o   <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      dmem_req_o   <= w_req_nxt;
      dmem_we_o    <= w_we_nxt;
      dmem_addr_o  <= w_addr_nxt;
      dmem_wdata_o <= w_wdata_nxt;
      ALU_Res_o    <= w_alu_nxt;
      Mem_Data_o   <= w_mdata_nxt;
      RdAddr_o     <= w_rd_nxt;
      MemToReg_o   <= w_m2r_nxt;
      RegWrite_o   <= w_rw_nxt;
      misalign_o   <= w_mis_nxt;
      timeout_o    <= w_tmo_nxt;
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage directly downstream of the EX/MEM pipeline register, consuming its ALU result, store data, destination register and control bits.
- Drives a req/ack data-memory port and stalls the upstream pipeline while an access is outstanding.
- Produces the registered MEM/WB pipeline outputs.
- Handles misaligned word accesses and memory timeouts.

Parameters:
TIMEOUT, 255, max BUSY cycles without dmem_ack_i before abort (1..65535)
CNT_W, 16, width of timeout counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
ALU_Res_i  in  32  address or ALU result from EX/MEM
Write_Data_i  in  32  store data from EX/MEM
RdAddr_i  in  5  destination register
MemToReg_i  in  1  writeback selects memory data
RegWrite_i  in  1  writeback enable
MemWrite_i  in  1  store
MemRead_i  in  1  load
stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
dmem_req_o  out  1  memory request, registered
dmem_we_o  out  1  1 = write, registered
dmem_addr_o  out  32  word address, registered
dmem_wdata_o  out  32  store data, registered
dmem_ack_i  in  1  access complete; rdata valid same cycle
dmem_rdata_i  in  32  load data
ALU_Res_o  out  32  MEM/WB ALU result
Mem_Data_o  out  32  MEM/WB load data
RdAddr_o  out  5  MEM/WB destination
MemToReg_o  out  1  MEM/WB control
RegWrite_o  out  1  MEM/WB control
misalign_o  out  1  one-cycle pulse aligned with the retiring faulty instruction
timeout_o  out  1  sticky timeout flag

Behaviour:
- Reset: clk_i edge with rst_i=1 sets state IDLE, counter 0, and all registered outputs to 0; stall_o=0 while in IDLE with no memop. Reset mid-access abandons the request: dmem_req_o=0 after that edge. A late dmem_ack_i arriving in IDLE is ignored.
- memop = MemRead_i | MemWrite_i. aligned = ALU_Res_i[1:0]==0. MemRead_i and MemWrite_i both set: treated as store.
- FSM states IDLE and BUSY.
- IDLE, no memop:
  - Pass-through; MEM/WB latches the *_i fields at next edge (latency 1).
  - Mem_Data_o holds its value.
  - stall_o=0.
- IDLE, memop, misaligned:
  - No request issued; stall_o=0.
  - Next edge: RegWrite_o=0, MemToReg_o=0, RdAddr_o/ALU_Res_o latched, misalign_o=1 for one cycle.
- IDLE, memop, aligned:
  - stall_o=1.
  - Next edge:
    - state BUSY.
    - dmem_req_o=1, dmem_we_o=MemWrite_i, dmem_addr_o=ALU_Res_i, dmem_wdata_o=Write_Data_i.
    - Counter cleared.
    - MEM/WB loaded with a bubble (RegWrite_o=0, MemToReg_o=0).
- BUSY:
  - dmem_req_o, dmem_we_o, dmem_addr_o and dmem_wdata_o held stable.
  - stall_o = ~dmem_ack_i.
  - Bubble written to MEM/WB each cycle without ack.
  - Counter increments each cycle.
- BUSY, dmem_ack_i=1:
  - stall_o=0 in the same cycle, so EX/MEM advances on that edge.
  - Next edge: dmem_req_o=0, state IDLE.
  - MEM/WB latches RdAddr_i, RegWrite_i, MemToReg_i and ALU_Res_i.
  - Mem_Data_o = dmem_rdata_i for a load; unchanged for a store.
- BUSY, counter == TIMEOUT-1 with no ack:
  - stall_o=0 in that cycle.
  - Next edge: dmem_req_o=0, state IDLE, timeout_o=1 (sticky until reset), instruction retired with RegWrite_o=0.
- The instruction that follows a completed access is seen in IDLE the cycle after completion. No request is reissued for an already-retired instruction.
- Minimum memop latency: 2 cycles (detect + ack in first BUSY cycle). Stall cycles = 1 + number of BUSY cycles without ack.

Test Plan:
- ALU op: ALU_Res_i=0x1234, RdAddr_i=5, RegWrite_i=1, no memop -> next cycle ALU_Res_o=0x1234, RdAddr_o=5, RegWrite_o=1; stall_o never asserted; dmem_req_o stays 0.
- Load addr 0x100, RdAddr_i=7, ack after 3 BUSY cycles with rdata 0xDEADBEEF:
  - dmem_addr_o=0x100, we=0.
  - stall_o high for 4 cycles.
  - Then Mem_Data_o=0xDEADBEEF, RdAddr_o=7, RegWrite_o=1, MemToReg_o=1.
  - Exactly one request.
- Store addr 0x20, data 0xCAFEF00D, ack in first BUSY cycle -> dmem_we_o=1, wdata=0xCAFEF00D; stall_o high 1 cycle; RegWrite_o=0; Mem_Data_o unchanged.
- Load addr 0x102 -> no dmem_req_o; misalign_o pulses 1 cycle; RegWrite_o=0; stall_o=0.
- TIMEOUT=4, load with ack never asserted:
  - dmem_req_o high 4 cycles then 0.
  - timeout_o=1 and stays 1.
  - Pipeline released; a following ALU op completes normally.
- rst_i=1 in the 2nd BUSY cycle of a load -> next edge all outputs 0, state IDLE; ack pulsed afterwards causes no MEM/WB update.
